// File: rtl/hw1_alu_sequencer.sv
// hw1_alu_sequencer: two-requester scheduler/sequencer for a shared 8-bit
// add/sub/rotate datapath. Arbitrates requests, drives the datapath through
// EXEC / ROT x N / CAPT, captures the registered result, and returns it on a
// valid/ready response channel.
// Optional build macro HW1_SEQ_STATS_EN adds STAT_CNT, a pair of saturating
// 16-bit per-requester completion counters.
//
// Response handshake: RESP_VALID rises in RESP and stays high, with RESP_DATA
// and RESP_ID frozen, until a clock edge where RESP_VALID && RESP_READY; that
// edge completes the transfer and returns the FSM to IDLE. No grant is given
// while a response is pending.

module hw1_alu_sequencer #(
    parameter int DW        = 8,
    parameter int CW        = 3,
    parameter int PRIO_MODE = 0
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic [1:0]      REQ,
    input  logic [3:0]      REQ_OP,
    input  logic [2*DW-1:0] REQ_A,
    input  logic [2*DW-1:0] REQ_B,
    output logic [1:0]      GNT,
    output logic            RESP_VALID,
    input  logic            RESP_READY,
    output logic [DW-1:0]   RESP_DATA,
    output logic            RESP_ID,
    output logic            BUSY,
    output logic [DW-1:0]   DP_IN1,
    output logic [DW-1:0]   DP_IN2,
    output logic [2:0]      DP_CTRL,
    input  logic [DW-1:0]   DP_OUT
`ifdef HW1_SEQ_STATS_EN
    ,
    output logic [31:0]     STAT_CNT
`endif
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_EXEC = 3'd1,
        S_ROT  = 3'd2,
        S_CAPT = 3'd3,
        S_RESP = 3'd4
    } state_t;

    state_t        state_q, state_d;
    logic          ptr_q;        // requester favoured on a tie (round-robin)
    logic [1:0]    op_q;         // 00 add, 01 sub, 10 rotl, 11 rotr
    logic [DW-1:0] a_q;
    logic [DW-1:0] b_q;
    logic          id_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [DW-1:0] data_q;

    logic [1:0]    arb_gnt;
    logic          arb_id;
    logic          accept;

    // Arbiter: pick one requester from REQ (fixed priority or round-robin)
    always_comb begin
        arb_gnt = 2'b00;
        if (PRIO_MODE != 0) begin
            if (REQ[0])      arb_gnt = 2'b01;
            else if (REQ[1]) arb_gnt = 2'b10;
        end else begin
            if (REQ == 2'b11) arb_gnt = ptr_q ? 2'b10 : 2'b01;
            else              arb_gnt = REQ;
        end
    end

    assign arb_id = arb_gnt[1];
    assign accept = (state_q == S_IDLE) && (REQ != 2'b00);

    // Next-state, grant and datapath drive; everything defaults to idle values
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        GNT     = 2'b00;
        DP_CTRL = 3'b000;
        DP_IN1  = '0;
        DP_IN2  = '0;
        case (state_q)
            S_IDLE: begin
                if (REQ != 2'b00) begin
                    GNT     = arb_gnt;
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                DP_IN1 = a_q;
                case (op_q)
                    2'b00: begin
                        DP_CTRL = 3'b110;
                        DP_IN2  = b_q;
                    end
                    2'b01: begin
                        DP_CTRL = 3'b100;
                        DP_IN2  = b_q;
                    end
                    default: begin
                        // Rotate load step: datapath computes A + 0
                        DP_CTRL = 3'b110;
                        DP_IN2  = '0;
                    end
                endcase
                cnt_d = b_q[CW-1:0];
                if (op_q[1] && (b_q[CW-1:0] != '0)) state_d = S_ROT;
                else                                 state_d = S_CAPT;
            end
            S_ROT: begin
                // DIR=1 rotates left; rotate-left opcode is 10
                DP_CTRL = {2'b00, ~op_q[0]};
                cnt_d   = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) state_d = S_CAPT;
            end
            S_CAPT: begin
                state_d = S_RESP;
            end
            S_RESP: begin
                if (RESP_READY) state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State register, rotate counter and round-robin pointer
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            ptr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) ptr_q <= ~arb_id;
        end
    end

    // Latch the granted request's opcode, operands and owner
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            op_q <= 2'b00;
            a_q  <= '0;
            b_q  <= '0;
            id_q <= 1'b0;
        end else if (accept) begin
            op_q <= arb_id ? REQ_OP[3:2]        : REQ_OP[1:0];
            a_q  <= arb_id ? REQ_A[2*DW-1:DW]   : REQ_A[DW-1:0];
            b_q  <= arb_id ? REQ_B[2*DW-1:DW]   : REQ_B[DW-1:0];
            id_q <= arb_id;
        end
    end

    // Capture the datapath output on the edge leaving CAPT
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            data_q <= '0;
        end else if (state_q == S_CAPT) begin
            data_q <= DP_OUT;
        end
    end

    assign RESP_VALID = (state_q == S_RESP);
    assign RESP_DATA  = data_q;
    assign RESP_ID    = id_q;
    assign BUSY       = (state_q != S_IDLE);

`ifdef HW1_SEQ_STATS_EN
    logic [15:0] stat0_q;
    logic [15:0] stat1_q;

    // Saturating completion counters, bumped on each response handshake
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            stat0_q <= '0;
            stat1_q <= '0;
        end else if ((state_q == S_RESP) && RESP_READY) begin
            if (id_q) begin
                if (stat1_q != 16'hFFFF) stat1_q <= stat1_q + 16'd1;
            end else begin
                if (stat0_q != 16'hFFFF) stat0_q <= stat0_q + 16'd1;
            end
        end
    end

    assign STAT_CNT = {stat1_q, stat0_q};
`endif

endmodule

// File: tb/tb_hw1_alu_sequencer.sv
// Bench for hw1_alu_sequencer: a round-robin and a fixed-priority instance
// share stimulus; each has its own behavioural datapath. Directed vector
// table, randomized ops against a reference model, and hand-written
// sequences for stall, mid-op reset and arbitration order.

module tb_hw1_alu_sequencer;

  logic clk = 1'b0;
  logic rst_n;
  logic [1:0] req;
  logic [3:0] req_op;
  logic [15:0] req_a;
  logic [15:0] req_b;
  logic resp_ready;

  logic [1:0] gnt_rr, gnt_fp;
  logic rv_rr, rv_fp, rid_rr, rid_fp, busy_rr, busy_fp;
  logic [7:0] rd_rr, rd_fp, in1_rr, in1_fp, in2_rr, in2_fp, dpo_rr, dpo_fp;
  logic [2:0] ctrl_rr, ctrl_fp;
`ifdef HW1_SEQ_STATS_EN
  logic [31:0] stat_rr, stat_fp;
`endif

  int n_checks = 0;
  int n_fail = 0;
  int hs0 = 0;
  int hs1 = 0;
  logic [7:0] exp_q[$];

  // clock / reset
  always #5 clk = ~clk;

  hw1_alu_sequencer #(.DW(8), .CW(3), .PRIO_MODE(0)) dut_rr (
    .CLK(clk), .RST(rst_n), .REQ(req), .REQ_OP(req_op), .REQ_A(req_a), .REQ_B(req_b),
    .GNT(gnt_rr), .RESP_VALID(rv_rr), .RESP_READY(resp_ready), .RESP_DATA(rd_rr),
    .RESP_ID(rid_rr), .BUSY(busy_rr), .DP_IN1(in1_rr), .DP_IN2(in2_rr),
    .DP_CTRL(ctrl_rr), .DP_OUT(dpo_rr)
`ifdef HW1_SEQ_STATS_EN
    , .STAT_CNT(stat_rr)
`endif
  );

  hw1_alu_sequencer #(.DW(8), .CW(3), .PRIO_MODE(1)) dut_fp (
    .CLK(clk), .RST(rst_n), .REQ(req), .REQ_OP(req_op), .REQ_A(req_a), .REQ_B(req_b),
    .GNT(gnt_fp), .RESP_VALID(rv_fp), .RESP_READY(resp_ready), .RESP_DATA(rd_fp),
    .RESP_ID(rid_fp), .BUSY(busy_fp), .DP_IN1(in1_fp), .DP_IN2(in2_fp),
    .DP_CTRL(ctrl_fp), .DP_OUT(dpo_fp)
`ifdef HW1_SEQ_STATS_EN
    , .STAT_CNT(stat_fp)
`endif
  );

  // behavioural datapath: registered output, MODE=1 add/sub, MODE=0 rotate own output
  function automatic logic [7:0] dp_next(input logic [7:0] cur, input logic [2:0] c,
                                         input logic [7:0] i1, input logic [7:0] i2);
    if (c[2]) return c[1] ? (i1 + i2) : (i1 - i2);
    return c[0] ? {cur[6:0], cur[7]} : {cur[0], cur[7:1]};
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dpo_rr <= 8'h00;
      dpo_fp <= 8'h00;
    end else begin
      dpo_rr <= dp_next(dpo_rr, ctrl_rr, in1_rr, in2_rr);
      dpo_fp <= dp_next(dpo_fp, ctrl_fp, in1_fp, in2_fp);
    end
  end

  // reference model: result of one request from its opcode and operands
  function automatic logic [7:0] ref_result(input logic [1:0] op, input logic [7:0] a,
                                            input logic [7:0] b);
    int n, av, bv;
    n = int'(b) % 8;
    av = int'(a);
    bv = int'(b);
    case (op)
      2'b00: return 8'((av + bv) % 256);
      2'b01: return 8'((av - bv + 256) % 256);
      2'b10: return 8'(((av << n) | (av >> (8 - n))) % 256);
      default: return 8'(((av >> n) | (av << (8 - n))) % 256);
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // driver: one request from requester id, checked end to end; starts and ends at negedge
  task automatic run_op(input int id, input logic [1:0] op, input logic [7:0] a,
                        input logic [7:0] b, input int stall, input bit raise_other,
                        input logic [7:0] exp_data, input int exp_lat);
    int cyc;
    logic [18:0] exp_exec;
    req_op[id*2 +: 2] = op;
    req_a[id*8 +: 8] = a;
    req_b[id*8 +: 8] = b;
    req[id] = 1'b1;
    resp_ready = (stall == 0);
    #1;
    check("gnt_cycle0", {30'd0, gnt_rr}, (id == 1) ? 32'd2 : 32'd1);
    @(posedge clk);
    @(negedge clk);
    req[id] = 1'b0;
    cyc = 1;
    case (op)
      2'b00: exp_exec = {3'b110, a, b};
      2'b01: exp_exec = {3'b100, a, b};
      default: exp_exec = {3'b110, a, 8'h00};
    endcase
    check("exec_drive", {13'd0, ctrl_rr, in1_rr, in2_rr}, {13'd0, exp_exec});
    while (!rv_rr && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (cyc == 2 && op[1] && b[2:0] != 3'd0)
        check("rot_ctrl", {29'd0, ctrl_rr}, {29'd0, 2'b00, ~op[0]});
    end
    check("latency", cyc, exp_lat);
    check("resp_data", {24'd0, rd_rr}, {24'd0, exp_data});
    check("resp_id", {31'd0, rid_rr}, id);
    for (int s = 0; s < stall; s++) begin
      if (s == 0 && raise_other) req[1-id] = 1'b1;
      @(negedge clk);
      check("stall_hold", {20'd0, rv_rr, rd_rr, rid_rr, gnt_rr},
            {20'd0, 1'b1, exp_data, id[0], 2'b00});
    end
    resp_ready = 1'b1;
    @(negedge clk);
    check("idle_after_hs", {30'd0, busy_rr, rv_rr}, 32'd0);
    if (id == 0) hs0++;
    else hs1++;
  endtask

  typedef struct {
    int id;
    logic [1:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] exp_d;
    int exp_lat;
  } vec_t;

  vec_t vecs[9];
  int ng;
  int grr[4];
  int gfp[4];
  int rid, rlat, rst_cnt;
  logic [1:0] rop;
  logic [7:0] ra, rb;

  initial begin
    vecs[0] = '{0, 2'b00, 8'h25, 8'h13, 8'h38, 3};
    vecs[1] = '{1, 2'b01, 8'h10, 8'h20, 8'hF0, 3};
    vecs[2] = '{0, 2'b10, 8'h81, 8'h03, 8'h0C, 6};
    vecs[3] = '{1, 2'b11, 8'h01, 8'h01, 8'h80, 4};
    vecs[4] = '{0, 2'b10, 8'hA5, 8'h00, 8'hA5, 3};
    vecs[5] = '{1, 2'b11, 8'h96, 8'h07, 8'h2D, 10};
    vecs[6] = '{0, 2'b00, 8'hFF, 8'h01, 8'h00, 3};
    vecs[7] = '{1, 2'b01, 8'h00, 8'h01, 8'hFF, 3};
    vecs[8] = '{0, 2'b11, 8'h3C, 8'hF9, 8'h1E, 4};

    rst_n = 1'b0;
    req = 2'b00;
    req_op = 4'h0;
    req_a = 16'h0;
    req_b = 16'h0;
    resp_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("reset_rr", {gnt_rr, rv_rr, rd_rr, rid_rr, busy_rr, in1_rr, in2_rr, ctrl_rr}, 32'd0);
    check("reset_fp", {gnt_fp, rv_fp, rd_fp, rid_fp, busy_fp, in1_fp, in2_fp, ctrl_fp}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // directed vector table
    for (int i = 0; i < 9; i++)
      run_op(vecs[i].id, vecs[i].op, vecs[i].a, vecs[i].b, 0, 1'b0,
             vecs[i].exp_d, vecs[i].exp_lat);

    // randomized ops against the reference model, random READY stalls
    for (int i = 0; i < 30; i++) begin
      rid = $urandom_range(0, 1);
      rop = 2'($urandom_range(0, 3));
      ra = 8'($urandom);
      rb = 8'($urandom);
      rlat = rop[1] ? 3 + int'(rb[2:0]) : 3;
      exp_q.push_back(ref_result(rop, ra, rb));
      run_op(rid, rop, ra, rb, $urandom_range(0, 2), 1'b0, exp_q.pop_front(), rlat);
    end

    // READY low 5 cycles with the other requester waiting; then it is granted at once
    req_op[3:2] = 2'b00;
    req_a[15:8] = 8'h07;
    req_b[15:8] = 8'h01;
    run_op(0, 2'b00, 8'h40, 8'h02, 5, 1'b1, 8'h42, 3);
    run_op(1, 2'b00, 8'h07, 8'h01, 0, 1'b0, 8'h08, 3);

    // reset in the middle of a count-7 rotate
    req_op[3:2] = 2'b10;
    req_a[15:8] = 8'h5A;
    req_b[15:8] = 8'h07;
    req[1] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req[1] = 1'b0;
    repeat (3) @(negedge clk);
    check("midop_in_rot", {28'd0, busy_rr, ctrl_rr}, {28'd0, 1'b1, 3'b001});
    #2 rst_n = 1'b0;
    #1;
    check("midop_reset", {gnt_rr, rv_rr, rd_rr, rid_rr, busy_rr, in1_rr, in2_rr, ctrl_rr}, 32'd0);
    hs0 = 0;
    hs1 = 0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_op(0, 2'b00, 8'h11, 8'h22, 0, 1'b0, 8'h33, 3);
`ifdef HW1_SEQ_STATS_EN
    check("stat_cnt", stat_rr, {16'(hs1), 16'(hs0)});
`endif

    // reset pointer, then both requesters held for four back-to-back adds
    rst_n = 1'b0;
    #1;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    req_op = 4'b0000;
    req_a = 16'h2010;
    req_b = 16'h0201;
    req = 2'b11;
    ng = 0;
    for (int c = 0; c < 40 && ng < 4; c++) begin
      #1;
      if (gnt_rr != 2'b00) begin
        grr[ng] = int'(gnt_rr[1]);
        gfp[ng] = int'(gnt_fp[1]);
        ng++;
      end
      @(negedge clk);
    end
    req = 2'b00;
    check("arb_grant_count", ng, 4);
    for (int k = 0; k < 4; k++) begin
      check("rr_order", grr[k], k % 2);
      check("fp_order", gfp[k], 0);
    end
    rst_cnt = 0;
    while ((busy_rr || busy_fp) && rst_cnt < 40) begin
      @(negedge clk);
      rst_cnt++;
    end
    check("drain", {30'd0, busy_rr, busy_fp}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
